// File: rtl/dp_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dp_mem_pkg
// Purpose  : Shared definitions for the dual-port byte-enabled memory:
//            read-during-write mode encodings, clear FSM state encodings
//            and the per-byte merge helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package dp_mem_pkg;

  // Same-port read-during-write behaviour (RD_MODE parameter values)
  localparam int RD_FIRST = 0;
  localparam int WR_FIRST = 1;

  // Clear FSM state encodings
  typedef logic [1:0] clr_state_t;
  localparam clr_state_t ST_RST   = 2'd0;
  localparam clr_state_t ST_CLEAR = 2'd1;
  localparam clr_state_t ST_READY = 2'd2;

  // Select the new byte when its enable is set, otherwise keep the old byte
  function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       en);
    return en ? new_b : old_b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dp_mem_if.sv
`default_nettype none
// ============================================================================
// Module   : dp_mem_if
// Purpose  : Bus bundle for the dual-port memory (both ports plus status).
// Ports    : wea/bea/addra/dina/douta   - port A
//            web/beb/addrb/dinb/doutb   - port B
//            busy, collision, perr      - status from the memory
//            modport master drives the ports, modport slave is the memory.
// Revision : 1.0 - initial release
// ============================================================================
interface dp_mem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 13
);
  logic                  wea;
  logic [DATA_W/8-1:0]   bea;
  logic [ADDR_W-1:0]     addra;
  logic [DATA_W-1:0]     dina;
  logic [DATA_W-1:0]     douta;
  logic                  web;
  logic [DATA_W/8-1:0]   beb;
  logic [ADDR_W-1:0]     addrb;
  logic [DATA_W-1:0]     dinb;
  logic [DATA_W-1:0]     doutb;
  logic                  busy;
  logic                  collision;
  logic [1:0]            perr;

  modport master (
    output wea, bea, addra, dina, web, beb, addrb, dinb,
    input  douta, doutb, busy, collision, perr
  );

  modport slave (
    input  wea, bea, addra, dina, web, beb, addrb, dinb,
    output douta, doutb, busy, collision, perr
  );
endinterface
`default_nettype wire

// File: rtl/dp_mem_lane_merge.sv
`default_nettype none
// ============================================================================
// Module   : dp_mem_lane_merge
// Purpose  : Combinational byte-enable merge of an old word with write data.
// Ports    : old_word - current memory contents
//            wr_data  - incoming write data
//            be       - byte enables, bit i selects wr_data[8i+7:8i]
//            merged   - resulting word
// Revision : 1.0 - initial release
// ============================================================================
module dp_mem_lane_merge
  import dp_mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]   old_word,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   merged
);
  localparam int c_NB = DATA_W / 8;

  generate
    for (genvar i = 0; i < c_NB; i++) begin : g_lane
      assign merged[8*i +: 8] = merge_byte(old_word[8*i +: 8], wr_data[8*i +: 8], be[i]);
    end
  endgenerate
endmodule
`default_nettype wire

// File: rtl/dp_mem_param.sv
`default_nettype none
// ============================================================================
// Module   : dp_mem_param
// Purpose  : True dual-port, byte-enabled, single-clock memory with optional
//            zero-fill after reset and optional per-byte parity.
//            Optional feature macro: DP_MEM_PARITY_EN (per-lane even parity).
// Ports    : clk   - clock, rising edge
//            rst_n - synchronous active-low reset
//            bus   - dp_mem_if.slave: port A/B write strobe, byte enables,
//                    address, data in, registered data out; busy,
//                    collision pulse and per-port parity error.
// Revision : 1.0 - initial release
// ============================================================================
module dp_mem_param
  import dp_mem_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 13,
  parameter int RD_MODE        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  dp_mem_if.slave  bus
);
  localparam int               c_DEPTH = 2 ** ADDR_W;
  localparam int               c_NB    = DATA_W / 8;
  localparam logic [ADDR_W:0]  c_LAST  = (ADDR_W + 1)'(c_DEPTH);

  logic [DATA_W-1:0] r_mem [c_DEPTH];
  clr_state_t        r_state;
  logic [ADDR_W:0]   r_cnt;
  logic [DATA_W-1:0] r_douta, r_doutb;
  logic              r_coll;

  logic              w_ready, w_clr, w_wra, w_wrb, w_both;
  logic [DATA_W-1:0] w_olda, w_oldb, w_basea, w_mrga, w_mrgb, w_rda, w_rdb;
  logic [ADDR_W:0]   w_cnt_nxt;

  assign w_ready   = rst_n && (r_state == ST_READY);
  assign w_clr     = rst_n && (r_state == ST_CLEAR);
  assign w_wra     = w_ready && bus.wea;
  assign w_wrb     = w_ready && bus.web;
  assign w_both    = w_wra && w_wrb && (bus.addra == bus.addrb);
  assign w_cnt_nxt = r_cnt + 1'b1;

  assign w_olda = r_mem[bus.addra];
  assign w_oldb = r_mem[bus.addrb];

  // On a same-address double write, A merges on top of B's merged word so
  // A wins shared lanes and B keeps its own lanes; only A's write is issued.
  assign w_basea = w_both ? w_mrgb : w_olda;

  dp_mem_lane_merge #(.DATA_W(DATA_W)) u_merge_b (
    .old_word (w_oldb),
    .wr_data  (bus.dinb),
    .be       (bus.beb),
    .merged   (w_mrgb)
  );

  dp_mem_lane_merge #(.DATA_W(DATA_W)) u_merge_a (
    .old_word (w_basea),
    .wr_data  (bus.dina),
    .be       (bus.bea),
    .merged   (w_mrga)
  );

  assign w_rda = (RD_MODE == WR_FIRST && w_wra) ? w_mrga : w_olda;
  assign w_rdb = (RD_MODE == WR_FIRST && w_wrb) ? w_mrgb : w_oldb;

  // Clear FSM; counter is one bit wider so it parks at DEPTH instead of
  // wrapping back onto address 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_RST;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_RST: begin
          r_state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
          r_cnt   <= '0;
        end
        ST_CLEAR: begin
          r_cnt <= w_cnt_nxt;
          if (w_cnt_nxt == c_LAST) r_state <= ST_READY;
        end
        ST_READY: r_state <= ST_READY;
        default:  r_state <= ST_RST;
      endcase
    end
  end

  // Array is deliberately not reset; only the clear sequence zeroes it.
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_mem[r_cnt[ADDR_W-1:0]] <= '0;
    end else begin
      if (w_wra)            r_mem[bus.addra] <= w_mrga;
      if (w_wrb && !w_both) r_mem[bus.addrb] <= w_mrgb;
    end
  end

  // Read data and collision; outputs are forced to 0 outside READY.
  always_ff @(posedge clk) begin
    if (!w_ready) begin
      r_douta <= '0;
      r_doutb <= '0;
      r_coll  <= 1'b0;
    end else begin
      r_douta <= w_rda;
      r_doutb <= w_rdb;
      r_coll  <= w_both;
    end
  end

  assign bus.douta     = r_douta;
  assign bus.doutb     = r_doutb;
  assign bus.collision = r_coll;
  assign bus.busy      = (CLEAR_ON_RESET != 0) ? (r_state != ST_READY) : 1'b0;

`ifdef DP_MEM_PARITY_EN
  logic [c_NB-1:0] r_par [c_DEPTH];
  logic [1:0]      r_perr;
  logic [c_NB-1:0] w_pwa, w_pwb, w_prda, w_prdb, w_lpa, w_lpb;

  // Parity only changes for enabled lanes; untouched lanes keep their stored
  // bit so a latent error is not silently repaired by a partial write.
  generate
    for (genvar i = 0; i < c_NB; i++) begin : g_par
      assign w_pwb[i] = bus.beb[i] ? ^bus.dinb[8*i +: 8] : r_par[bus.addrb][i];
      assign w_pwa[i] = bus.bea[i] ? ^bus.dina[8*i +: 8]
                      : (w_both ? w_pwb[i] : r_par[bus.addra][i]);
      assign w_lpa[i] = ^w_rda[8*i +: 8];
      assign w_lpb[i] = ^w_rdb[8*i +: 8];
    end
  endgenerate

  assign w_prda = (RD_MODE == WR_FIRST && w_wra) ? w_pwa : r_par[bus.addra];
  assign w_prdb = (RD_MODE == WR_FIRST && w_wrb) ? w_pwb : r_par[bus.addrb];

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_par[r_cnt[ADDR_W-1:0]] <= '0;
    end else begin
      if (w_wra)            r_par[bus.addra] <= w_pwa;
      if (w_wrb && !w_both) r_par[bus.addrb] <= w_pwb;
    end
  end

  always_ff @(posedge clk) begin
    if (!w_ready) r_perr <= 2'b00;
    else          r_perr <= {|(w_prdb ^ w_lpb), |(w_prda ^ w_lpa)};
  end

  assign bus.perr = r_perr;
`else
  assign bus.perr = 2'b00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dp_mem_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_dp_mem_param
// Purpose  : Directed self-checking bench for dp_mem_param (DATA_W=32,
//            ADDR_W=4). dut0: read-first, dut1: write-first, dut2: read-first
//            without clear-on-reset. All share one stimulus.
//            Optional feature macro: DP_MEM_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dp_mem_param;
  logic        clk;
  logic        rst_n;
  logic        wea, web;
  logic [3:0]  bea, beb;
  logic [3:0]  addra, addrb;
  logic [31:0] dina, dinb;
  int          n_checks;
  int          n_errors;
  int          cycles;

  dp_mem_if #(.DATA_W(32), .ADDR_W(4)) if0 ();
  dp_mem_if #(.DATA_W(32), .ADDR_W(4)) if1 ();
  dp_mem_if #(.DATA_W(32), .ADDR_W(4)) if2 ();

  assign if0.wea = wea;   assign if1.wea = wea;   assign if2.wea = wea;
  assign if0.bea = bea;   assign if1.bea = bea;   assign if2.bea = bea;
  assign if0.addra = addra; assign if1.addra = addra; assign if2.addra = addra;
  assign if0.dina = dina; assign if1.dina = dina; assign if2.dina = dina;
  assign if0.web = web;   assign if1.web = web;   assign if2.web = web;
  assign if0.beb = beb;   assign if1.beb = beb;   assign if2.beb = beb;
  assign if0.addrb = addrb; assign if1.addrb = addrb; assign if2.addrb = addrb;
  assign if0.dinb = dinb; assign if1.dinb = dinb; assign if2.dinb = dinb;

  dp_mem_param #(.DATA_W(32), .ADDR_W(4), .RD_MODE(0), .CLEAR_ON_RESET(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0));
  dp_mem_param #(.DATA_W(32), .ADDR_W(4), .RD_MODE(1), .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1));
  dp_mem_param #(.DATA_W(32), .ADDR_W(4), .RD_MODE(0), .CLEAR_ON_RESET(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wea = 1'b0; web = 1'b0; bea = 4'h0; beb = 4'h0;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; idle();
    addra = '0; addrb = '0; dina = '0; dinb = '0;

    // Reset state
    tick(); tick();
    chk("rst_douta",  if0.douta, 32'h0);
    chk("rst_doutb",  if0.doutb, 32'h0);
    chk("rst_doutb1", if1.doutb, 32'h0);
    chk("rst_coll",   {31'b0, if0.collision}, 32'h0);
    chk("rst_perr",   {30'b0, if0.perr}, 32'h0);
    chk("rst_busy",   {31'b0, if0.busy}, 32'h1);
    chk("rst_busy_nc", {31'b0, if2.busy}, 32'h0);

    // Release reset; writes attempted during the clear must be dropped
    rst_n = 1'b1;
    wea = 1'b1; bea = 4'hF; addra = 4'd5; dina = 32'hFFFF_FFFF;
    cycles = 0;
    while (if0.busy && cycles < 40) begin
      tick();
      cycles++;
      chk("clr_douta", if0.douta, 32'h0);
    end
    chk("busy_len", cycles, 32'd17);
    chk("busy_nc",  {31'b0, if2.busy}, 32'h0);
    idle();

    // All words read back zero on both ports
    for (int a = 0; a < 16; a++) begin
      addra = 4'(a); addrb = 4'(15 - a);
      tick();
      chk("clr_rd_a", if0.douta, 32'h0);
      chk("clr_rd_b", if0.doutb, 32'h0);
    end

    // Full write then read, 1-cycle latency
    wea = 1'b1; bea = 4'hF; addra = 4'd6; dina = 32'h0000_0039;
    tick();
    chk("wr_rdfirst", if0.douta, 32'h0);
    chk("wr_wrfirst", if1.douta, 32'h0000_0039);
    idle();
    tick();
    chk("rd_39", if0.douta, 32'h0000_0039);

    // Partial byte-enable write
    wea = 1'b1; bea = 4'hF; dina = 32'h1122_3344;
    tick();
    bea = 4'b0101; dina = 32'hAABB_CCDD;
    tick();
    chk("be_rdfirst", if0.douta, 32'h1122_3344);
    chk("be_wrfirst", if1.douta, 32'h11BB_33DD);
    idle();
    tick();
    chk("be_merge", if0.douta, 32'h11BB_33DD);

    // Write strobe with no enables leaves memory unchanged
    wea = 1'b1; bea = 4'h0; dina = 32'hFFFF_FFFF;
    tick();
    idle();
    tick();
    chk("be_none", if0.douta, 32'h11BB_33DD);

    // Same-address double write with overlapping enables
    wea = 1'b1; bea = 4'b0011; addra = 4'd3; dina = 32'hAAAA_AAAA;
    web = 1'b1; beb = 4'b1111; addrb = 4'd3; dinb = 32'h5555_5555;
    tick();
    chk("coll_pulse", {31'b0, if0.collision}, 32'h1);
    idle();
    tick();
    chk("coll_end", {31'b0, if0.collision}, 32'h0);
    chk("coll_word_a", if0.douta, 32'h5555_AAAA);
    chk("coll_word_b", if0.doutb, 32'h5555_AAAA);

    // Same-address double write, disjoint enables still flags collision
    wea = 1'b1; bea = 4'b0001; addra = 4'd4; dina = 32'hAAAA_AAAA;
    web = 1'b1; beb = 4'b1000; addrb = 4'd4; dinb = 32'h5555_5555;
    tick();
    chk("coll_disj", {31'b0, if0.collision}, 32'h1);
    idle();
    tick();
    chk("coll_disj_end", {31'b0, if0.collision}, 32'h0);
    chk("coll_disj_word", if0.douta, 32'h5500_00AA);

    // Different-address double write: no collision, both land
    wea = 1'b1; bea = 4'hF; addra = 4'd8; dina = 32'hCAFE_F00D;
    web = 1'b1; beb = 4'hF; addrb = 4'd9; dinb = 32'h0BAD_BEEF;
    tick();
    chk("nocoll", {31'b0, if0.collision}, 32'h0);
    idle();
    tick();
    chk("dual_wr_a", if0.douta, 32'hCAFE_F00D);
    chk("dual_wr_b", if0.doutb, 32'h0BAD_BEEF);

    // Read-during-write modes and cross-port old data
    wea = 1'b1; bea = 4'hF; addra = 4'd7; dina = 32'h1;
    tick();
    dina = 32'h2; addrb = 4'd7;
    tick();
    chk("rdw_rdfirst", if0.douta, 32'h1);
    chk("rdw_wrfirst", if1.douta, 32'h2);
    chk("xport_old0",  if0.doutb, 32'h1);
    chk("xport_old1",  if1.doutb, 32'h1);
    idle();

    // Parity
    wea = 1'b1; bea = 4'hF; addra = 4'd2; dina = 32'h1234_5678;
    tick();
    idle();
`ifdef DP_MEM_PARITY_EN
    dut0.r_par[2] = dut0.r_par[2] ^ 4'b0001;
    tick();
    chk("perr_flip", {30'b0, if0.perr}, 32'h1);
    chk("perr_data", if0.douta, 32'h1234_5678);
    chk("perr_clean", {30'b0, if1.perr}, 32'h0);
`else
    tick();
    chk("perr_off", {30'b0, if0.perr}, 32'h0);
    chk("perr_data", if0.douta, 32'h1234_5678);
`endif

    // Array survives reset; port activity during reset is ignored
    wea = 1'b1; bea = 4'hF; addra = 4'd12; dina = 32'h0000_ABCD;
    tick();
    rst_n = 1'b0; dina = 32'hFFFF_FFFF;
    tick();
    chk("rst2_douta", if0.douta, 32'h0);
    chk("rst2_douta_nc", if2.douta, 32'h0);
    rst_n = 1'b1; idle();
    tick();
    tick();
    chk("nc_keep", if2.douta, 32'h0000_ABCD);

    // Reset in the middle of the clear (counter at 9) restarts it
    for (int k = 0; k < 8; k++) tick();
    chk("mid_busy", {31'b0, if0.busy}, 32'h1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    cycles = 0;
    while (if0.busy && cycles < 40) begin
      tick();
      cycles++;
    end
    chk("busy_len2", cycles, 32'd17);
    for (int a = 2; a < 16; a += 5) begin
      addra = 4'(a);
      tick();
      chk("reclr_rd", if0.douta, 32'h0);
    end
    addra = 4'd12;
    tick();
    chk("reclr_rd12", if0.douta, 32'h0);
    chk("reclr_perr", {30'b0, if0.perr}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
